// File: rtl/riscv_pkg.sv
// Shared RV32 MEM-stage definitions: funct3 encodings, FSM state, request and
// MEM/WB payloads, plus alignment and store-lane helpers.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned STRB_W   = XLEN / 8;

    localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                we;
        logic                reg_write;
        logic                mem_to_reg;
        logic [FUNCT3_W-1:0] funct3;
        logic [XLEN-1:0]     addr;
        logic [XLEN-1:0]     wdata;
        logic [STRB_W-1:0]   wstrb;
        logic [REG_W-1:0]    rd;
    } mem_req_t;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic [XLEN-1:0]     alu_result;
        logic [XLEN-1:0]     mem_data;
        logic [REG_W-1:0]    rd;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '0;

    function automatic logic is_aligned(input logic [FUNCT3_W-1:0] funct3,
                                        input logic [1:0]          addr_lo);
        logic ok;
        case (funct3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~addr_lo[0];
            F3_W:        ok = (addr_lo == 2'b00);
            default:     ok = (addr_lo == 2'b00);  // undefined encodings act as word
        endcase
        return ok;
    endfunction

    function automatic logic [STRB_W-1:0] store_strb(input logic [FUNCT3_W-1:0] funct3,
                                                     input logic [1:0]          addr_lo);
        logic [STRB_W-1:0] strb;
        case (funct3)
            F3_B:    strb = 4'b0001 << addr_lo;
            F3_H:    strb = 4'b0011 << {addr_lo[1], 1'b0};
            default: strb = 4'hF;
        endcase
        return strb;
    endfunction

    function automatic logic [XLEN-1:0] store_wdata(input logic [FUNCT3_W-1:0] funct3,
                                                    input logic [XLEN-1:0]     data);
        logic [XLEN-1:0] wd;
        case (funct3)
            F3_B:    wd = {4{data[7:0]}};
            F3_H:    wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of a read word.
module load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0]     rdata,
    input  logic [1:0]          addr_lo,
    input  logic [FUNCT3_W-1:0] funct3,
    output logic [XLEN-1:0]     data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = 8'h00;
        case (addr_lo)
            2'd0:    byte_c = rdata[7:0];
            2'd1:    byte_c = rdata[15:8];
            2'd2:    byte_c = rdata[23:16];
            default: byte_c = rdata[31:24];
        endcase
        half_c = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data_c = rdata;
        case (funct3)
            F3_B:    data_c = {{(XLEN-8){byte_c[7]}}, byte_c};
            F3_BU:   data_c = {{(XLEN-8){1'b0}}, byte_c};
            F3_H:    data_c = {{(XLEN-16){half_c[15]}}, half_c};
            F3_HU:   data_c = {{(XLEN-16){1'b0}}, half_c};
            default: data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs loads/stores over the request/ready data-memory port, stalls
// upstream while an access is in flight, and owns the MEM/WB register.
module mem_access_unit
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic                mem_to_reg_in,
    input  logic                reg_write_in,
    input  logic [XLEN-1:0]     alu_result_in,
    input  logic [XLEN-1:0]     rs2_data_in,
    input  logic [REG_W-1:0]    rd_in,
    input  logic [FUNCT3_W-1:0] funct3_in,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    output logic [STRB_W-1:0]   dmem_wstrb,
    input  logic                dmem_ready,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                stall,
    output logic                reg_write_out,
    output logic                mem_to_reg_out,
    output logic [XLEN-1:0]     alu_result_out,
    output logic [XLEN-1:0]     mem_data_out,
    output logic [REG_W-1:0]    rd_out,
    output logic                misalign_err
);

    mem_state_t      state, state_nxt;
    mem_req_t        req, req_nxt;
    mem_wb_t         mem_wb, mem_wb_nxt;
    logic            dmem_req_nxt;
    logic            misalign_nxt;
    logic            mem_op_c;
    logic            aligned_c;
    logic [XLEN-1:0] load_data_c;

    assign mem_op_c  = mem_read_in | mem_write_in;
    assign aligned_c = is_aligned(funct3_in, alu_result_in[1:0]);

    load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (req.addr[1:0]),
        .funct3  (req.funct3),
        .data_c  (load_data_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            req          <= '0;
            mem_wb       <= MEM_WB_BUBBLE;
            dmem_req     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            req          <= req_nxt;
            mem_wb       <= mem_wb_nxt;
            dmem_req     <= dmem_req_nxt;
            misalign_err <= misalign_nxt;
        end
    end

    // Anything that does not complete this cycle leaves a bubble in MEM/WB.
    always_comb begin
        state_nxt    = state;
        req_nxt      = req;
        mem_wb_nxt   = MEM_WB_BUBBLE;
        dmem_req_nxt = dmem_req;
        misalign_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op_c) begin
                    if (aligned_c) begin
                        req_nxt.we         = mem_write_in;
                        req_nxt.reg_write  = reg_write_in;
                        req_nxt.mem_to_reg = mem_to_reg_in;
                        req_nxt.funct3     = funct3_in;
                        req_nxt.addr       = alu_result_in;
                        req_nxt.wdata      = store_wdata(funct3_in, rs2_data_in);
                        req_nxt.wstrb      = mem_write_in ? store_strb(funct3_in, alu_result_in[1:0])
                                                          : '0;
                        req_nxt.rd         = rd_in;
                        state_nxt          = BUSY;
                        dmem_req_nxt       = 1'b1;
                    end else begin
                        misalign_nxt = 1'b1;
                    end
                end else begin
                    mem_wb_nxt.reg_write  = reg_write_in;
                    mem_wb_nxt.mem_to_reg = mem_to_reg_in;
                    mem_wb_nxt.alu_result = alu_result_in;
                    mem_wb_nxt.mem_data   = '0;
                    mem_wb_nxt.rd         = rd_in;
                end
            end
            BUSY: begin
                if (dmem_ready) begin
                    mem_wb_nxt.reg_write  = req.reg_write;
                    mem_wb_nxt.mem_to_reg = req.mem_to_reg;
                    mem_wb_nxt.alu_result = req.addr;
                    mem_wb_nxt.mem_data   = load_data_c;
                    mem_wb_nxt.rd         = req.rd;
                    state_nxt             = IDLE;
                    dmem_req_nxt          = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall = ((state == IDLE) & mem_op_c & aligned_c) | ((state == BUSY) & ~dmem_ready);

    assign dmem_we        = req.we;
    assign dmem_addr      = {req.addr[ADDR_W-1:2], 2'b00};
    assign dmem_wdata     = req.wdata;
    assign dmem_wstrb     = req.wstrb;

    assign reg_write_out  = mem_wb.reg_write;
    assign mem_to_reg_out = mem_wb.mem_to_reg;
    assign alu_result_out = mem_wb.alu_result;
    assign mem_data_out   = mem_wb.mem_data;
    assign rd_out         = mem_wb.rd;

endmodule
